// File: rtl/flappy_game_ctrl.sv
// flappy_game_ctrl
//   Per-frame game controller for the flappy bird demo. It watches the bird
//   and pipe positions produced by the motion blocks and the USB keycode, and
//   from them it:
//     - detects collisions with the pipe, the ground and the ceiling,
//     - detects pipe passes and keeps a saturating two-digit BCD score,
//     - runs the IDLE -> PLAY -> DEAD flow.
//   On every entry to PLAY it raises restart for one frame, so the motion
//   blocks re-center on the following frame.
//
// Ports
//   frame_clk   in   clock, one rising edge per video frame
//   Reset       in   asynchronous, active-high reset
//   keycode     in   [7:0] current USB keycode (8'h00 = no key)
//   BirdX/Y/S   in   [9:0] bird center and half-size
//   PipeX/Y     in   [9:0] pipe center X and gap center Y
//   state       out  [1:0] 0 IDLE, 1 PLAY, 2 DEAD
//   playing     out  state is PLAY
//   game_over   out  state is DEAD
//   score_bcd   out  [7:0] tens in [7:4], ones in [3:0]
//   pipe_passed out  one-frame pulse per score increment
//   restart     out  one-frame pulse on each entry to PLAY
module flappy_game_ctrl #(
  parameter int         PIPE_HALF_W = 20,
  parameter int         GAP_HALF    = 60,
  parameter int         GROUND_Y    = 440,
  parameter logic [7:0] KEY_START   = 8'h2C,
  parameter int         DEAD_HOLD   = 60
) (
  input  logic       frame_clk,
  input  logic       Reset,
  input  logic [7:0] keycode,
  input  logic [9:0] BirdX,
  input  logic [9:0] BirdY,
  input  logic [9:0] BirdS,
  input  logic [9:0] PipeX,
  input  logic [9:0] PipeY,
  output logic [1:0] state,
  output logic       playing,
  output logic       game_over,
  output logic [7:0] score_bcd,
  output logic       pipe_passed,
  output logic       restart
);

  localparam int HOLD_W = (DEAD_HOLD < 2) ? 1 : $clog2(DEAD_HOLD + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PLAY = 2'd1,
    S_DEAD = 2'd2,
    S_BAD  = 2'd3
  } state_t;

  // Lower bound clamped at zero so pipes at the screen edge never wrap.
  function automatic logic [10:0] lo(input logic [10:0] a, input logic [10:0] b);
    return (a < b) ? 11'd0 : a - b;
  endfunction

  // Two-digit BCD increment that sticks at 99.
  function automatic logic [7:0] bcd_inc_sat(input logic [7:0] s);
    if (s == 8'h99)
      return s;
    else if (s[3:0] == 4'd9)
      return {s[7:4] + 4'd1, 4'd0};
    else
      return {s[7:4], s[3:0] + 4'd1};
  endfunction

  state_t              state_q;
  logic [7:0]          prev_key;
  logic                behind_q;
  logic [HOLD_W-1:0]   hold_cnt;

  // 11-bit views so sums of two 10-bit coordinates cannot overflow.
  logic [10:0] bx, by, bs, px, py, phw, gh, gy;
  assign bx  = {1'b0, BirdX};
  assign by  = {1'b0, BirdY};
  assign bs  = {1'b0, BirdS};
  assign px  = {1'b0, PipeX};
  assign py  = {1'b0, PipeY};
  assign phw = 11'(PIPE_HALF_W);
  assign gh  = 11'(GAP_HALF);
  assign gy  = 11'(GROUND_Y);

  logic h_ov, v_out, hit, behind, pass, start_edge, go_play;

  assign h_ov   = (bx + bs >= lo(px, phw)) && (lo(bx, bs) <= px + phw);
  assign v_out  = (lo(by, bs) < lo(py, gh)) || (by + bs > py + gh);
  assign hit    = (h_ov && v_out) || (by + bs >= gy) || (by < bs);
  // behind falls again when the pipe wraps to the right edge, re-arming pass.
  assign behind = (px + phw) < lo(bx, bs);
  assign pass   = behind && !behind_q;

  assign start_edge = (keycode == KEY_START) && (prev_key != KEY_START);
  assign go_play    = start_edge &&
                      ((state_q == S_IDLE) ||
                       ((state_q == S_DEAD) && (hold_cnt == '0)));

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      state_q     <= S_IDLE;
      playing     <= 1'b0;
      game_over   <= 1'b0;
      score_bcd   <= 8'h00;
      pipe_passed <= 1'b0;
      restart     <= 1'b0;
      prev_key    <= 8'h00;
      behind_q    <= 1'b1;
      hold_cnt    <= '0;
    end else begin
      prev_key    <= keycode;
      behind_q    <= behind;
      pipe_passed <= 1'b0;
      restart     <= 1'b0;
      if (go_play) begin
        state_q   <= S_PLAY;
        playing   <= 1'b1;
        game_over <= 1'b0;
        score_bcd <= 8'h00;
        restart   <= 1'b1;
      end else begin
        case (state_q)
          S_IDLE: ;
          S_PLAY: begin
            // restart high means positions are still pre-restart; skip hit.
            if (hit && !restart) begin
              state_q   <= S_DEAD;
              playing   <= 1'b0;
              game_over <= 1'b1;
              hold_cnt  <= HOLD_W'(DEAD_HOLD);
            end else if (pass && (score_bcd != 8'h99)) begin
              score_bcd   <= bcd_inc_sat(score_bcd);
              pipe_passed <= 1'b1;
            end
          end
          S_DEAD: begin
            if (hold_cnt != '0)
              hold_cnt <= hold_cnt - HOLD_W'(1);
          end
          default: begin
            state_q   <= S_IDLE;
            playing   <= 1'b0;
            game_over <= 1'b0;
          end
        endcase
      end
    end
  end

  assign state = state_q;

endmodule
